asynfifo_err_event_arbiter: RTL and testbench

Collects single-cycle async-FIFO error pulses from every RX/TX port FIFO and shares one counter-update path among them through a round-robin arbiter. Each source has a 16-bit saturating event counter. The counters are readable (optionally clear-on-read) by the management/register block. The block sits beside the existing LED-pulse aggregation and receives the same event pulses, already synchronized into `i_clk`.

---
 rtl/asynfifo_err_event_arbiter_pkg.sv | 38 +++
 rtl/asynfifo_err_event_arbiter_if.sv | 33 +++
 rtl/asynfifo_err_event_arbiter_rr_arbiter.sv | 57 +++++
 rtl/asynfifo_err_event_arbiter.sv | 121 ++++++++++++
 tb/tb_asynfifo_err_event_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/asynfifo_err_event_arbiter_pkg.sv
// Shared definitions for the async-FIFO error event arbiter: default sizes
// and the fixed mapping of FIFO error sources onto event/counter indices.
package asynfifo_err_pkg;

    // Default geometry: 15 sources, 16-bit counters, 4-bit read address.
    localparam int NUM_SRC_DEF = 15;
    localparam int CNT_W_DEF   = 16;
    localparam int ADDR_W_DEF  = 4;

    // Source index map. Bit k of the event vector and counter k both refer
    // to the FIFO named here; the register block decodes with these values.
    typedef enum logic [3:0] {
        SRC_HOST_RX_OVF = 4'd0,
        SRC_HOST_RX_UDF = 4'd1,
        SRC_P0_RX_OVF   = 4'd2,
        SRC_P0_RX_UDF   = 4'd3,
        SRC_P1_RX_OVF   = 4'd4,
        SRC_P1_RX_UDF   = 4'd5,
        SRC_P2_RX_OVF   = 4'd6,
        SRC_P2_RX_UDF   = 4'd7,
        SRC_P3_RX_OVF   = 4'd8,
        SRC_P3_RX_UDF   = 4'd9,
        SRC_HOST_TX_OVF = 4'd10,
        SRC_P0_TX_OVF   = 4'd11,
        SRC_P1_TX_OVF   = 4'd12,
        SRC_P2_TX_OVF   = 4'd13,
        SRC_P3_TX_OVF   = 4'd14
    } src_idx_e;

    // Convenience: one-hot event mask for a named source.
    function automatic logic [NUM_SRC_DEF-1:0] src_mask(input src_idx_e src);
        logic [NUM_SRC_DEF-1:0] m;
        m = '0;
        m[src] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/asynfifo_err_event_arbiter_if.sv
// Event/read bus between the error event arbiter and its environment
// (FIFO error pulses in, management read port and status out).
interface asynfifo_err_event_arbiter_if
    import asynfifo_err_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) ();

    logic [NUM_SRC-1:0] i_event_pulse;
    logic               i_rd_req;
    logic [ADDR_W-1:0]  i_rd_addr;
    logic               i_rd_clr;
    logic               i_lost_clr;
    logic               o_rd_valid;
    logic [CNT_W-1:0]   o_rd_data;
    logic [NUM_SRC-1:0] o_event_lost;
    logic               o_any_err;

    // Environment side: drives pulses and read requests, observes results.
    modport master (
        output i_event_pulse, i_rd_req, i_rd_addr, i_rd_clr, i_lost_clr,
        input  o_rd_valid, o_rd_data, o_event_lost, o_any_err
    );

    // Arbiter side.
    modport slave (
        input  i_event_pulse, i_rd_req, i_rd_addr, i_rd_clr, i_lost_clr,
        output o_rd_valid, o_rd_data, o_event_lost, o_any_err
    );

endinterface

// File: rtl/asynfifo_err_event_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks one pending request per cycle, searching from
// the slot after the last grant. The search pointer lives here and only
// moves when a grant is issued.
module rr_arbiter
    import asynfifo_err_pkg::*;
#(
    parameter int N = NUM_SRC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_vld
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] cand;

    // (base + off) mod N for off in [0, N]; base is always < N.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(32'(base)) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return PTR_W'(sum);
    endfunction

    // First pending request at or after the pointer wins; pointer moves past it.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        ptr_d   = ptr_q;
        cand    = ptr_q;
        for (int i = 0; i < N; i++) begin
            cand = wrap_add(ptr_q, i);
            if (!gnt_vld && req[cand]) begin
                gnt_vld   = 1'b1;
                gnt[cand] = 1'b1;
                ptr_d     = wrap_add(cand, 1);
            end
        end
    end

    // Pointer register; source 0 has top priority out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/asynfifo_err_event_arbiter.sv
// Async-FIFO error event arbiter. Each source's one-cycle error pulse is
// latched as pending, a round-robin arbiter grants one pending source per
// cycle, and the granted source's saturating counter is bumped. Counters are
// read through a one-cycle-latency port with optional clear-on-read.
module asynfifo_err_event_arbiter
    import asynfifo_err_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    asynfifo_err_event_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] lost_q, lost_d;
    logic [NUM_SRC-1:0] gnt;
    logic               gnt_vld;
    logic [NUM_SRC-1:0] upd;
    logic [NUM_SRC-1:0] drop;
    logic [NUM_SRC-1:0] clr_hit;
    logic [CNT_W-1:0]   cnt_q [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d [NUM_SRC];
    logic               rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic               any_err_q, any_err_d;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_arb (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .req     (pend_q),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    // Pending latch and sticky loss flags: a pulse on a source that is still
    // waiting (pending and not granted this cycle) cannot be queued and is lost.
    always_comb begin
        upd    = gnt & {NUM_SRC{gnt_vld}};
        drop   = bus.i_event_pulse & pend_q & ~upd;
        pend_d = bus.i_event_pulse | (pend_q & ~upd);
        lost_d = bus.i_lost_clr ? '0 : (lost_q | drop);
    end

    // Read decode: capture the pre-update counter value; out-of-range
    // addresses return zero and never clear anything.
    always_comb begin
        clr_hit    = '0;
        rd_data_d  = '0;
        rd_valid_d = bus.i_rd_req;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.i_rd_req && (bus.i_rd_addr == ADDR_W'(k))) begin
                rd_data_d  = cnt_q[k];
                clr_hit[k] = bus.i_rd_clr;
            end
        end
    end

    // Counter next state: a clear that coincides with a grant leaves 1 so the
    // granted event is still counted.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_hit[k]) begin
                cnt_d[k] = upd[k] ? CNT_W'(1) : '0;
            end else if (upd[k]) begin
                cnt_d[k] = sat_inc(cnt_q[k]);
            end
        end
    end

    // Summary flag source: any counter currently nonzero.
    always_comb begin
        any_err_d = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cnt_q[k] != '0) begin
                any_err_d = 1'b1;
            end
        end
    end

    // State registers; reset drops pending events and any in-flight read.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend_q     <= '0;
            lost_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            any_err_q  <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            pend_q     <= pend_d;
            lost_q     <= lost_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            any_err_q  <= any_err_d;
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.o_rd_valid   = rd_valid_q;
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_event_lost = lost_q;
    assign bus.o_any_err    = any_err_q;

endmodule

// File: tb/tb_asynfifo_err_event_arbiter.sv
// Directed bench for asynfifo_err_event_arbiter: a vector table for the
// basic count/read/any_err behaviour plus scripted multi-cycle sequences.
module tb_asynfifo_err_event_arbiter;
    import asynfifo_err_pkg::*;

    localparam int NS = 15;
    localparam int CW = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    asynfifo_err_event_arbiter_if #(.NUM_SRC(NS), .CNT_W(CW), .ADDR_W(AW)) bus ();

    asynfifo_err_event_arbiter #(
        .NUM_SRC (NS),
        .CNT_W   (CW),
        .ADDR_W  (AW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [NS-1:0] pulse;
        logic          rd_req;
        logic [AW-1:0] addr;
        logic          rd_clr;
        logic          lost_clr;
        logic          exp_valid;
        logic [CW-1:0] exp_data;
        logic [NS-1:0] exp_lost;
        logic          exp_any;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [NS-1:0] pulse, input logic rd_req,
                                input logic [AW-1:0] addr, input logic rd_clr,
                                input logic lost_clr, input logic exp_valid,
                                input logic [CW-1:0] exp_data,
                                input logic [NS-1:0] exp_lost, input logic exp_any);
        vec_t v;
        v.pulse = pulse;   v.rd_req = rd_req;       v.addr = addr;
        v.rd_clr = rd_clr; v.lost_clr = lost_clr;   v.exp_valid = exp_valid;
        v.exp_data = exp_data; v.exp_lost = exp_lost; v.exp_any = exp_any;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NS-1:0] pulse, input logic rd_req,
                         input logic [AW-1:0] addr, input logic rd_clr, input logic lost_clr);
        bus.i_event_pulse = pulse;
        bus.i_rd_req      = rd_req;
        bus.i_rd_addr     = addr;
        bus.i_rd_clr      = rd_clr;
        bus.i_lost_clr    = lost_clr;
    endtask

    task automatic idle();
        drive('0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic clr,
                           input logic [CW-1:0] exp, input string name);
        drive('0, 1'b1, addr, clr, 1'b0);
        step();
        check({name, "_vld"}, 32'(bus.o_rd_valid), 32'd1);
        check(name, 32'(bus.o_rd_data), 32'(exp));
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Table: single event on source 3, clear-on-read, any_err timing,
        // out-of-range reads that must neither return data nor clear.
        vecs[0]  = mk(15'h0008, 0, 4'd0,  0, 0, 0, 16'd0, '0, 0);
        vecs[1]  = mk(15'h0000, 0, 4'd0,  0, 0, 0, 16'd0, '0, 0);
        vecs[2]  = mk(15'h0000, 1, 4'd3,  0, 0, 1, 16'd1, '0, 1);
        vecs[3]  = mk(15'h0000, 1, 4'd3,  1, 0, 1, 16'd1, '0, 1);
        vecs[4]  = mk(15'h0000, 1, 4'd3,  0, 0, 1, 16'd0, '0, 0);
        vecs[5]  = mk(15'h0000, 1, 4'd15, 0, 0, 1, 16'd0, '0, 0);
        vecs[6]  = mk(15'h0000, 1, 4'd15, 1, 0, 1, 16'd0, '0, 0);
        vecs[7]  = mk(15'h0000, 0, 4'd0,  0, 0, 0, 16'd0, '0, 0);
        vecs[8]  = mk(15'h4000, 0, 4'd0,  0, 0, 0, 16'd0, '0, 0);
        vecs[9]  = mk(15'h0000, 0, 4'd0,  0, 0, 0, 16'd0, '0, 0);
        vecs[10] = mk(15'h0000, 1, 4'd15, 1, 0, 1, 16'd0, '0, 1);
        vecs[11] = mk(15'h0000, 1, 4'd14, 0, 0, 1, 16'd1, '0, 1);
        vecs[12] = mk(15'h0000, 1, 4'd14, 1, 0, 1, 16'd1, '0, 1);
        vecs[13] = mk(15'h0000, 1, 4'd14, 0, 0, 1, 16'd0, '0, 0);

        // Reset state.
        rst_n = 1'b0;
        idle();
        step();
        step();
        check("rst_rd_valid", 32'(bus.o_rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
        check("rst_lost", 32'(bus.o_event_lost), 32'd0);
        check("rst_any_err", 32'(bus.o_any_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].pulse, vecs[i].rd_req, vecs[i].addr, vecs[i].rd_clr, vecs[i].lost_clr);
            step();
            check($sformatf("vec%0d_valid", i), 32'(bus.o_rd_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), 32'(bus.o_rd_data), 32'(vecs[i].exp_data));
            end
            check($sformatf("vec%0d_lost", i), 32'(bus.o_event_lost), 32'(vecs[i].exp_lost));
            check($sformatf("vec%0d_any", i), 32'(bus.o_any_err), 32'(vecs[i].exp_any));
        end
        idle();

        // All 15 sources at once: source j is granted exactly j cycles after
        // the first grant, so reading j in that slot still shows 0.
        do_reset();
        drive(15'h7FFF, 1'b0, '0, 1'b0, 1'b0);
        step();
        for (int j = 0; j < NS; j++) begin
            do_read(AW'(j), 1'b0, 16'd0, $sformatf("all_pre%0d", j));
        end
        for (int j = 0; j < NS; j++) begin
            do_read(AW'(j), 1'b0, 16'd1, $sformatf("all_cnt%0d", j));
        end
        check("all_lost", 32'(bus.o_event_lost), 32'd0);
        check("all_any", 32'(bus.o_any_err), 32'd1);

        // Source 5 pulses twice while 0..4 are ahead of it: second is lost.
        do_reset();
        drive(15'h003F, 1'b0, '0, 1'b0, 1'b0);
        step();
        drive(15'h0020, 1'b0, '0, 1'b0, 1'b0);
        step();
        check("lost5_set", 32'(bus.o_event_lost), 32'h20);
        idle();
        repeat (6) step();
        do_read(AW'(SRC_P1_RX_UDF), 1'b0, 16'd1, "lost_cnt5");
        do_read(4'd0, 1'b0, 16'd1, "lost_cnt0");
        check("lost5_sticky", 32'(bus.o_event_lost), 32'h20);
        drive('0, 1'b0, '0, 1'b0, 1'b1);
        step();
        check("lost_clr", 32'(bus.o_event_lost), 32'h0);
        // Clear coinciding with a new loss on source 1: clear wins.
        drive(15'h0003, 1'b0, '0, 1'b0, 1'b0);
        step();
        drive(15'h0002, 1'b0, '0, 1'b0, 1'b1);
        step();
        check("lost_clr_prio", 32'(bus.o_event_lost), 32'h0);
        idle();
        step();
        check("lost_clr_prio_hold", 32'(bus.o_event_lost), 32'h0);
        step();
        do_read(4'd1, 1'b0, 16'd2, "lost_cnt1");

        // Saturation on source 7: count to 0xFFFE, then three more events.
        do_reset();
        drive(src_mask(SRC_P2_RX_UDF), 1'b0, '0, 1'b0, 1'b0);
        repeat (65534) step();
        idle();
        check("sat_lost", 32'(bus.o_event_lost), 32'd0);
        step();
        step();
        do_read(4'd7, 1'b0, 16'hFFFE, "sat_pre");
        for (int p = 0; p < 3; p++) begin
            drive(src_mask(SRC_P2_RX_UDF), 1'b0, '0, 1'b0, 1'b0);
            step();
            idle();
            step();
            step();
            do_read(4'd7, 1'b0, 16'hFFFF, $sformatf("sat_p%0d", p));
        end

        // Read+clear in the same cycle as a grant to source 2.
        do_reset();
        drive(15'h0004, 1'b0, '0, 1'b0, 1'b0);
        repeat (4) step();
        idle();
        step();
        step();
        do_read(4'd2, 1'b0, 16'd4, "rc_pre");
        drive(15'h0004, 1'b0, '0, 1'b0, 1'b0);
        step();
        do_read(4'd2, 1'b1, 16'd4, "rc_clr");
        do_read(4'd2, 1'b0, 16'd1, "rc_after");
        do_read(4'd2, 1'b1, 16'd1, "rc_clr2");
        check("rc_any_hold", 32'(bus.o_any_err), 32'd1);
        step();
        check("rc_any_fall", 32'(bus.o_any_err), 32'd0);

        // Reset in the middle of a burst with six sources pending.
        drive(15'h003F, 1'b0, '0, 1'b0, 1'b0);
        step();
        idle();
        repeat (8) step();
        do_read(4'd4, 1'b0, 16'd1, "mid_pre");
        drive(15'h003F, 1'b0, '0, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        drive('0, 1'b1, 4'd0, 1'b0, 1'b0);
        step();
        check("mid_rd_valid", 32'(bus.o_rd_valid), 32'd0);
        check("mid_any", 32'(bus.o_any_err), 32'd0);
        idle();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check("mid_idle_valid", 32'(bus.o_rd_valid), 32'd0);
        for (int j = 0; j < NS; j++) begin
            do_read(AW'(j), 1'b0, 16'd0, $sformatf("mid_cnt%0d", j));
        end
        check("mid_any_after", 32'(bus.o_any_err), 32'd0);
        check("mid_lost_after", 32'(bus.o_event_lost), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
